elevator_call_panel: RTL and testbench



---
 rtl/elevator_pkg.sv | 19 +
 rtl/call_panel_conditioner.sv | 55 +++++
 rtl/elevator_call_panel.sv | 136 +++++++++++++
 tb/tb_elevator_call_panel.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator call panel.
// Optional input debouncing is enabled with CALL_PANEL_DEBOUNCE_EN.
package elevator_pkg;

  localparam int NUM_FLOORS_DEF      = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 8;
  localparam int HOLDOFF_CYCLES_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STOP    = 2'd1,
    HOLDOFF = 2'd2
  } estop_state_e;

  function automatic int floor_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/call_panel_conditioner.sv
// One raw button: 2-flop synchroniser, then a debouncer when CALL_PANEL_DEBOUNCE_EN is defined.
module call_panel_conditioner
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic cond_o
);

  if (DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("call_panel_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], async_i};
  end

`ifdef CALL_PANEL_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) level_d = sync_q[1];
      else                                       cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cond_o = level_q;
`else
  assign cond_o = sync_q[1];
`endif

endmodule

// File: rtl/elevator_call_panel.sv
// Call latching, service clearing and emergency stop/hold-off sequencing for the car controller.
// Input debouncing is compiled in with CALL_PANEL_DEBOUNCE_EN.
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS      = NUM_FLOORS_DEF,
  parameter int FLOOR_W         = floor_w(NUM_FLOORS),
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLDOFF_CYCLES  = HOLDOFF_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] btn_i,
  input  logic                  estop_btn_i,
  input  logic [FLOOR_W-1:0]    current_floor_i,
  input  logic                  door_open_i,
  output logic [NUM_FLOORS-1:0] floor_request_o,
  output logic                  emergency_stop_o,
  output logic [FLOOR_W:0]      pending_count_o,
  output logic                  served_o
);

  localparam int HO_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  if (NUM_FLOORS < 2 || NUM_FLOORS > 16 || HOLDOFF_CYCLES < 1) begin : g_param_check
    $error("elevator_call_panel: illegal parameter value");
  end

  // Bit NUM_FLOORS of the conditioned vector is the emergency button.
  logic [NUM_FLOORS:0] raw, cond, prev_q, rise;

  assign raw  = {estop_btn_i, btn_i};
  assign rise = cond & ~prev_q;

  for (genvar k = 0; k <= NUM_FLOORS; k++) begin : g_cond
    call_panel_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk    (clk),
      .rst_n  (rst_n),
      .async_i(raw[k]),
      .cond_o (cond[k])
    );
  end

  logic estop_cond, estop_rise;
  assign estop_cond = cond[NUM_FLOORS];
  assign estop_rise = rise[NUM_FLOORS];

  estop_state_e    state_q, state_d;
  logic [HO_W-1:0] ho_cnt_q, ho_cnt_d;
  logic            accept_calls, flush, estop_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ho_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ho_cnt_q <= ho_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ho_cnt_d = ho_cnt_q;
    case (state_q)
      IDLE: if (estop_rise) state_d = STOP;
      STOP: begin
        if (!estop_cond) begin
          state_d  = HOLDOFF;
          ho_cnt_d = HO_W'(HOLDOFF_CYCLES - 1);
        end
      end
      HOLDOFF: begin
        if (estop_rise)           state_d  = STOP;
        else if (ho_cnt_q == '0)  state_d  = IDLE;
        else                      ho_cnt_d = ho_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flush keys off the next state so the flush lands on the same edge as emergency_stop.
  always_comb begin
    accept_calls = (state_q == IDLE);
    flush        = (state_d == STOP);
    estop_d      = (state_d == STOP);
  end

  logic [NUM_FLOORS-1:0] pending_q, pending_d, svc, set_v, clr_v;
  logic [FLOOR_W:0]      count_q, count_d;
  logic                  served_q, served_d, estop_q;

  // Out-of-range floor indices match no bit, so nothing clears.
  always_comb begin
    svc = '0;
    for (int k = 0; k < NUM_FLOORS; k++) begin
      svc[k] = door_open_i && (current_floor_i == FLOOR_W'(k));
    end
  end

  always_comb begin
    set_v     = rise[NUM_FLOORS-1:0] & ~pending_q & ~svc & {NUM_FLOORS{accept_calls}};
    clr_v     = pending_q & svc;
    pending_d = (pending_q | set_v) & ~svc;
    if (flush) pending_d = '0;
    served_d  = |clr_v;
    count_d   = '0;
    for (int k = 0; k < NUM_FLOORS; k++) begin
      count_d = count_d + (FLOOR_W + 1)'(pending_d[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      pending_q <= '0;
      count_q   <= '0;
      served_q  <= 1'b0;
      estop_q   <= 1'b0;
    end else begin
      prev_q    <= cond;
      pending_q <= pending_d;
      count_q   <= count_d;
      served_q  <= served_d;
      estop_q   <= estop_d;
    end
  end

  assign floor_request_o  = pending_q;
  assign pending_count_o  = count_q;
  assign served_o         = served_q;
  assign emergency_stop_o = estop_q;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Scoreboard bench for elevator_call_panel; adapts latencies when CALL_PANEL_DEBOUNCE_EN is defined.
module tb_elevator_call_panel;

`ifdef CALL_PANEL_DEBOUNCE_EN
  localparam int DEB = 8;
  localparam int DL  = 2 + DEB;
`else
  localparam int DEB = 8;
  localparam int DL  = 2;
`endif
  localparam int LAT  = DL + 1;
  localparam int HOLD = LAT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_i;
  logic       estop_btn_i;
  logic [1:0] current_floor_i;
  logic       door_open_i;
  logic [3:0] floor_request_o;
  logic       emergency_stop_o;
  logic [2:0] pending_count_o;
  logic       served_o;

  elevator_call_panel #(
    .NUM_FLOORS     (4),
    .DEBOUNCE_CYCLES(DEB),
    .HOLDOFF_CYCLES (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .btn_i           (btn_i),
    .estop_btn_i     (estop_btn_i),
    .current_floor_i (current_floor_i),
    .door_open_i     (door_open_i),
    .floor_request_o (floor_request_o),
    .emergency_stop_o(emergency_stop_o),
    .pending_count_o (pending_count_o),
    .served_o        (served_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [3:0] req;
    logic       es;
    logic       srv;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int due, input logic [3:0] req, input logic es,
                          input logic srv, input string tag);
    exp_t e;
    e.due = due; e.req = req; e.es = es; e.srv = srv; e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "_ontime"}, 32'(cyc), 32'(e.due));
      chk({e.tag, "_req"},    32'(floor_request_o),  32'(e.req));
      chk({e.tag, "_cnt"},    32'(pending_count_o),  32'($countones(e.req)));
      chk({e.tag, "_estop"},  32'(emergency_stop_o), 32'(e.es));
      chk({e.tag, "_served"}, 32'(served_o),         32'(e.srv));
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      run(1);
      n++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x, f;
    rst_n = 1'b0; btn_i = '0; estop_btn_i = 1'b0;
    current_floor_i = '0; door_open_i = 1'b0;
    run(3);
    chk("rst_req",    32'(floor_request_o),  32'd0);
    chk("rst_cnt",    32'(pending_count_o),  32'd0);
    chk("rst_estop",  32'(emergency_stop_o), 32'd0);
    chk("rst_served", 32'(served_o),         32'd0);
    rst_n = 1'b1;
    run(2);

    // single call, held button gives one call
    x = cyc;
    push_exp(x + LAT - 1, 4'b0000, 0, 0, "s1_pre");
    push_exp(x + LAT,     4'b0100, 0, 0, "s1_set");
    push_exp(x + LAT + 2, 4'b0100, 0, 0, "s1_held");
    btn_i = 4'b0100; run(HOLD); btn_i = '0; run(LAT + 1); drain();

    // service clear of floor 3 out of 1010
    x = cyc;
    push_exp(x + LAT, 4'b0110, 0, 0, "s2_add");
    btn_i = 4'b0010; run(HOLD); btn_i = '0; run(LAT + 1); drain();
    x = cyc;
    current_floor_i = 2'd2; door_open_i = 1'b1;
    push_exp(x + 1, 4'b0010, 0, 1, "s2_clr2");
    run(1); door_open_i = 1'b0; run(1); drain();
    x = cyc;
    push_exp(x + LAT, 4'b1010, 0, 0, "s2_pend");
    btn_i = 4'b1000; run(HOLD); btn_i = '0; run(LAT + 1); drain();
    x = cyc;
    current_floor_i = 2'd3; door_open_i = 1'b1;
    push_exp(x + 1, 4'b0010, 0, 1, "s2_clr3");
    push_exp(x + 2, 4'b0010, 0, 0, "s2_pulse_end");
    run(2); door_open_i = 1'b0; drain();

    // press while that floor is being served is dropped; clear wins
    x = cyc;
    current_floor_i = 2'd1; door_open_i = 1'b1; btn_i = 4'b0010;
    push_exp(x + 1,       4'b0000, 0, 1, "s3_clr");
    push_exp(x + LAT + 1, 4'b0000, 0, 0, "s3_blocked");
    run(LAT + 1); btn_i = '0; door_open_i = 1'b0; run(LAT + 1); drain();
    x = cyc;
    push_exp(x + LAT, 4'b0010, 0, 0, "s3_set");
    btn_i = 4'b0010; run(HOLD); btn_i = '0; run(LAT + 1); drain();

    // emergency flush, hold-off, first accepted call 17 cycles after release
    x = cyc;
    push_exp(x + LAT, 4'b0111, 0, 0, "s4_pend");
    btn_i = 4'b0101; run(HOLD); btn_i = '0; run(LAT + 1); drain();
    x = cyc;
    push_exp(x + LAT - 1, 4'b0111, 0, 0, "s4_pre");
    push_exp(x + LAT,     4'b0000, 1, 0, "s4_stop");
    estop_btn_i = 1'b1; run(10); estop_btn_i = 1'b0;
    f = cyc;
    push_exp(f + DL,          4'b0000, 1, 0, "s4_stop_last");
    push_exp(f + DL + 1,      4'b0000, 0, 0, "s4_holdoff");
    push_exp(f + 16 + LAT,    4'b0000, 0, 0, "s4_ignored");
    push_exp(f + 17 + LAT,    4'b0001, 0, 0, "s4_accept");
    run(16); btn_i = 4'b0010;
    run(1);  btn_i = 4'b0011;
    run(HOLD - 1); btn_i = 4'b0001;
    run(1);  btn_i = '0;
    run(LAT + 2); drain();

    // async reset flushes pending calls immediately
    x = cyc;
    push_exp(x + LAT, 4'b1001, 0, 0, "s5_pend");
    btn_i = 4'b1000; run(HOLD); btn_i = '0; run(LAT + 1); drain();
    #3 rst_n = 1'b0;
    #1;
    chk("s5_rst_req", 32'(floor_request_o), 32'd0);
    chk("s5_rst_cnt", 32'(pending_count_o), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run(2);

    // async reset during STOP, then normal latency from IDLE
    x = cyc;
    push_exp(x + LAT, 4'b0000, 1, 0, "s6_stop");
    estop_btn_i = 1'b1; run(LAT + 1); drain();
    #3 rst_n = 1'b0;
    #1;
    chk("s6_rst_estop", 32'(emergency_stop_o), 32'd0);
    estop_btn_i = 1'b0;
    run(2); rst_n = 1'b1; run(1);
    x = cyc;
    push_exp(x + LAT - 1, 4'b0000, 0, 0, "s6_pre");
    push_exp(x + LAT,     4'b0100, 0, 0, "s6_after_rst");
    btn_i = 4'b0100; run(HOLD); btn_i = '0; run(LAT + 1); drain();

`ifdef CALL_PANEL_DEBOUNCE_EN
    // bounce is rejected; a stable level is accepted after 3+DEB edges
    x = cyc;
    push_exp(x + LAT + 10, 4'b0100, 0, 0, "s7_bounce");
    btn_i = 4'b0010; run(1); btn_i = '0; run(1);
    btn_i = 4'b0010; run(1); btn_i = '0;
    run(LAT + 10); drain();
    x = cyc;
    push_exp(x + LAT - 1, 4'b0100, 0, 0, "s7_pre");
    push_exp(x + LAT,     4'b0110, 0, 0, "s7_stable");
    btn_i = 4'b0010; run(HOLD); btn_i = '0; run(LAT + 1); drain();
`endif

    run(3);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
